// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the registered delay line.
package dff_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One data + valid register of the delay line.
// Reset and flush both clear the stage to an empty bubble.
module dff_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // Priority rst > flush > en > hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit registered delay line with per-stage valid,
// global stall, synchronous flush and a registered occupancy count.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       d_valid,
    input  logic [WIDTH-1:0]           d,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            vld;

    // Stage 0 takes the input word (bubbles carry RST_VAL so q never goes X);
    // every later stage copies its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             in_v;
        logic [WIDTH-1:0] in_d;

        if (i == 0) begin : g_head
            assign in_v = d_valid;
            assign in_d = d_valid ? d : RST_VAL;
        end else begin : g_body
            assign in_v = vld[i-1];
            assign in_d = data[i-1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .in_valid  (in_v),
            .in_data   (in_d),
            .out_valid (vld[i]),
            .out_data  (data[i])
        );
    end

    // Occupancy tracks accepts minus ejects; the result always stays in
    // 0..DEPTH, so plain modular arithmetic is exact.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(d_valid) - CW'(vld[DEPTH-1]);
        end
    end

    assign q_valid = vld[DEPTH-1];
    assign q       = data[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: DEPTH=4 and DEPTH=1 instances share stimulus.
// The driver pushes the hand-computed post-edge state per cycle; monitors
// pop and compare one entry after every rising edge.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    typedef struct {
        int         cnt;
        logic       qv;
        logic [7:0] q;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] d = 8'h00;

    logic       q_valid4, q_valid1;
    logic [7:0] q4, q1;
    logic [cnt_w(4)-1:0] count4;
    logic [cnt_w(1)-1:0] count1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t sb4[$];
    exp_t sb1[$];
    exp_t e4, e1;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d_valid(d_valid), .d(d),
        .q_valid(q_valid4), .q(q4), .count(count4)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d_valid(d_valid), .d(d),
        .q_valid(q_valid1), .q(q1), .count(count1)
    );

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the expected DEPTH=4 state after the edge.
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [7:0] dd, input int c, input logic qv, input logic [7:0] qq);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; flush = f; d_valid = v; d = dd;
        x.cnt = c; x.qv = qv; x.q = qq;
        sb4.push_back(x);
    endtask

    // Expected DEPTH=1 state after the same edge (call right after step).
    task automatic exp1(input int c, input logic qv, input logic [7:0] qq);
        exp_t x;
        x.cnt = c; x.qv = qv; x.q = qq;
        sb1.push_back(x);
    endtask

    // Monitor for the DEPTH=4 instance.
    always @(posedge clk) begin
        #1;
        if (sb4.size() > 0) begin
            e4 = sb4.pop_front();
            chk("d4_count",   int'(count4),   e4.cnt);
            chk("d4_q_valid", int'(q_valid4), int'(e4.qv));
            chk("d4_q",       int'(q4),       int'(e4.q));
        end
    end

    // Monitor for the DEPTH=1 instance.
    always @(posedge clk) begin
        #1;
        if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            chk("d1_count",   int'(count1),   e1.cnt);
            chk("d1_q_valid", int'(q_valid1), int'(e1.qv));
            chk("d1_q",       int'(q1),       int'(e1.q));
        end
    end

    initial begin
        // Reset with active-looking inputs.
        step(1, 1, 0, 1, 8'hFF, 0, 0, 8'h00);
        step(1, 1, 0, 1, 8'hFF, 0, 0, 8'h00);

        // Streaming, then drain with bubbles.
        step(0, 1, 0, 1, 8'h11, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'h22, 2, 0, 8'h00);
        step(0, 1, 0, 1, 8'h33, 3, 0, 8'h00);
        step(0, 1, 0, 1, 8'h44, 4, 1, 8'h11);
        step(0, 1, 0, 1, 8'h55, 4, 1, 8'h22);
        step(0, 1, 0, 0, 8'h00, 3, 1, 8'h33);
        step(0, 1, 0, 0, 8'h00, 2, 1, 8'h44);
        step(0, 1, 0, 0, 8'h00, 1, 1, 8'h55);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Stall: EE offered while en=0 must never enter.
        step(0, 1, 0, 1, 8'hA1, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'hA2, 2, 0, 8'h00);
        step(0, 0, 0, 1, 8'hEE, 2, 0, 8'h00);
        step(0, 0, 0, 1, 8'hEE, 2, 0, 8'h00);
        step(0, 0, 0, 1, 8'hEE, 2, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 2, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 2, 1, 8'hA1);
        step(0, 1, 0, 0, 8'h00, 1, 1, 8'hA2);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Bubbles: d on invalid cycles must not leak.
        step(0, 1, 0, 1, 8'h01, 1, 0, 8'h00);
        step(0, 1, 0, 0, 8'h02, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'h03, 2, 0, 8'h00);
        step(0, 1, 0, 0, 8'h04, 2, 1, 8'h01);
        step(0, 1, 0, 0, 8'h00, 1, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 1, 1, 8'h03);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Flush a full pipe; 77 offered in the flush cycle is dropped.
        step(0, 1, 0, 1, 8'hB1, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'hB2, 2, 0, 8'h00);
        step(0, 1, 0, 1, 8'hB3, 3, 0, 8'h00);
        step(0, 1, 0, 1, 8'hB4, 4, 1, 8'hB1);
        step(0, 1, 1, 1, 8'h77, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Reset mid-stream at count=3.
        step(0, 1, 0, 1, 8'hC1, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'hC2, 2, 0, 8'h00);
        step(0, 1, 0, 1, 8'hC3, 3, 0, 8'h00);
        step(1, 1, 0, 1, 8'hC4, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // DEPTH=1 instance checked alongside from here on.
        step(1, 1, 0, 1, 8'hFF, 0, 0, 8'h00); exp1(0, 0, 8'h00);
        step(0, 1, 0, 1, 8'h5A, 1, 0, 8'h00); exp1(1, 1, 8'h5A);
        step(0, 0, 0, 1, 8'h33, 1, 0, 8'h00); exp1(1, 1, 8'h5A);
        step(0, 1, 0, 1, 8'hC3, 2, 0, 8'h00); exp1(1, 1, 8'hC3);
        step(0, 1, 0, 0, 8'h99, 2, 0, 8'h00); exp1(0, 0, 8'h00);
        step(0, 1, 0, 1, 8'h6B, 3, 1, 8'h5A); exp1(1, 1, 8'h6B);
        step(0, 0, 1, 1, 8'h66, 0, 0, 8'h00); exp1(0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00); exp1(0, 0, 8'h00);

        // Let the monitors consume everything, bounded.
        begin
            int budget;
            budget = 20;
            while ((sb4.size() > 0 || sb1.size() > 0) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (sb4.size() > 0 || sb1.size() > 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_timeout: %0d/%0d entries left, expected 0",
                         sb4.size(), sb1.size());
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
